// File: rtl/dsi_seq_pkg.sv
// -----------------------------------------------------------------------------
// dsi_seq_pkg
// Shared definitions for the DSI power-up command sequencer: DCS data types and
// opcodes, the command ROM entry layout, wait selector codes, the FSM state
// encoding and a helper that folds the state into the 3-bit debug code.
// Optional feature macro: DSI_SHUTDOWN_EN (adds the DRAIN/OFF states and the
// display-off / sleep-in ROM entries).
// -----------------------------------------------------------------------------
package dsi_seq_pkg;

  // DSI data types for DCS short writes
  localparam logic [5:0] DT_DCS_SHORT0 = 6'h05;  // no parameter
  localparam logic [5:0] DT_DCS_SHORT1 = 6'h15;  // one parameter

  // DCS opcodes
  localparam logic [7:0] DCS_SLPOUT  = 8'h11;
  localparam logic [7:0] DCS_DISPON  = 8'h29;
  localparam logic [7:0] DCS_MADCTL  = 8'h36;
  localparam logic [7:0] DCS_COLMOD  = 8'h3A;
  localparam logic [7:0] DCS_DISPOFF = 8'h28;
  localparam logic [7:0] DCS_SLPIN   = 8'h10;

  // Which post-command delay to apply
  typedef enum logic [1:0] {
    WAIT_NONE   = 2'd0,
    WAIT_SLPOUT = 2'd1,
    WAIT_DISPON = 2'd2
  } wait_sel_t;

  typedef struct packed {
    logic [5:0] dt;
    logic [7:0] opcode;
    logic [7:0] param;
    wait_sel_t  wait_sel;
  } rom_entry_t;

  localparam int ROM_ENTRY_W = $bits(rom_entry_t);
  localparam int IDX_W       = 3;

  localparam logic [IDX_W-1:0] IDX_INIT_LAST  = 3'd3;
  localparam logic [IDX_W-1:0] IDX_SHDN_FIRST = 3'd4;
  localparam logic [IDX_W-1:0] IDX_SHDN_LAST  = 3'd5;

  typedef enum logic [3:0] {
    S_PWRUP_WAIT = 4'd0,
    S_LOAD       = 4'd1,
    S_ISSUE      = 4'd2,
    S_WAIT_BUSY  = 4'd3,
    S_WAIT_DONE  = 4'd4,
    S_DELAY      = 4'd5,
    S_RUN        = 4'd6,
    S_DRAIN      = 4'd7,
    S_OFF        = 4'd8
  } state_t;

  // The debug port is only 3 bits wide: the seven base states map directly,
  // DRAIN and OFF (shutdown build only) both report 7.
  function automatic logic [2:0] dbg_code(input state_t s);
    return (s == S_OFF) ? 3'd7 : 3'(s);
  endfunction

endpackage

// File: rtl/dsi_cmd_rom.sv
// -----------------------------------------------------------------------------
// dsi_cmd_rom
// Combinational index -> command lookup for the DSI init sequencer.
// Entries 0..3 are the power-up sequence; entries 4..5 (display-off, sleep-in)
// exist only when DSI_SHUTDOWN_EN is defined.
// Ports:
//   idx   in  IDX_W        ROM index
//   entry out rom_entry_t  {dt, opcode, param, wait_sel}
// -----------------------------------------------------------------------------
module dsi_cmd_rom
  import dsi_seq_pkg::*;
#(
  parameter logic [7:0] MADCTL_VAL = 8'h00,
  parameter logic [7:0] COLMOD_VAL = 8'h77
) (
  input  logic [IDX_W-1:0] idx,
  output rom_entry_t       entry
);

  always_comb begin
    entry = '{dt: 6'h00, opcode: 8'h00, param: 8'h00, wait_sel: WAIT_NONE};
    case (idx)
      3'd0: entry = '{dt: DT_DCS_SHORT0, opcode: DCS_SLPOUT, param: 8'h00,      wait_sel: WAIT_SLPOUT};
      3'd1: entry = '{dt: DT_DCS_SHORT1, opcode: DCS_MADCTL, param: MADCTL_VAL, wait_sel: WAIT_NONE};
      3'd2: entry = '{dt: DT_DCS_SHORT1, opcode: DCS_COLMOD, param: COLMOD_VAL, wait_sel: WAIT_NONE};
      3'd3: entry = '{dt: DT_DCS_SHORT0, opcode: DCS_DISPON, param: 8'h00,      wait_sel: WAIT_DISPON};
`ifdef DSI_SHUTDOWN_EN
      3'd4: entry = '{dt: DT_DCS_SHORT0, opcode: DCS_DISPOFF, param: 8'h00,     wait_sel: WAIT_NONE};
      3'd5: entry = '{dt: DT_DCS_SHORT0, opcode: DCS_SLPIN,   param: 8'h00,     wait_sel: WAIT_SLPOUT};
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/dsi_init_sequencer.sv
// -----------------------------------------------------------------------------
// dsi_init_sequencer
// Powers up a DSI panel by issuing the DCS sequence sleep-out, MADCTL, COLMOD,
// display-on through the packetizer short-packet path, honouring the panel
// delays and a pkt_busy handshake, then enables video.
// Optional feature macro: DSI_SHUTDOWN_EN (shutdown_req in RUN drains the link,
// sends display-off + sleep-in, parks in OFF; releasing it re-initialises).
// Ports:
//   byte_clk     in   1   clock
//   reset        in   1   synchronous active-high reset
//   pkt_busy     in   1   packetizer HS enable, high while a packet is sent
//   shutdown_req in   1   shutdown level request (shutdown build only)
//   pkt_req      out  1   one-cycle short-packet strobe
//   pkt_dt       out  6   data type
//   pkt_vc       out  2   virtual channel
//   pkt_wc       out  16  {param, opcode}
//   video_en     out  1   video long packets permitted
//   ini_done     out  1   initialisation complete
//   err          out  1   sticky pkt_busy timeout flag
//   state_dbg    out  3   state code
// -----------------------------------------------------------------------------
module dsi_init_sequencer
  import dsi_seq_pkg::*;
#(
  parameter int                 DELAY_W      = 24,
  parameter logic [DELAY_W-1:0] POWERUP_WAIT = 24'd100000,
  parameter logic [DELAY_W-1:0] SLPOUT_WAIT  = 24'd1500000,
  parameter logic [DELAY_W-1:0] DISPON_WAIT  = 24'd100000,
  parameter logic [7:0]         MADCTL_VAL   = 8'h00,
  parameter logic [7:0]         COLMOD_VAL   = 8'h77,
  parameter logic [1:0]         VC_ID        = 2'd0,
  parameter int                 BUSY_TO      = 16
) (
  input  logic        byte_clk,
  input  logic        reset,
  input  logic        pkt_busy,
  input  logic        shutdown_req,
  output logic        pkt_req,
  output logic [5:0]  pkt_dt,
  output logic [1:0]  pkt_vc,
  output logic [15:0] pkt_wc,
  output logic        video_en,
  output logic        ini_done,
  output logic        err,
  output logic [2:0]  state_dbg
);

  localparam logic [DELAY_W-1:0] BUSY_LAST = DELAY_W'(BUSY_TO - 1);
  localparam logic [DELAY_W-1:0] ONE       = DELAY_W'(1);

  state_t             state_reg, state_next;
  logic [DELAY_W-1:0] cnt_reg, cnt_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  wait_sel_t          wait_sel_reg, wait_sel_next;

  logic        req_reg, req_next;
  logic [5:0]  dt_reg, dt_next;
  logic [15:0] wc_reg, wc_next;
  logic        video_reg, video_next;
  logic        ini_reg, ini_next;
  logic        err_reg, err_next;
  logic [2:0]  dbg_reg, dbg_next;

  rom_entry_t         rom_q;
  logic [DELAY_W-1:0] wait_val;
  logic [DELAY_W-1:0] cnt_inc;
  logic               delay_done;
  logic               timeout;

`ifndef DSI_SHUTDOWN_EN
  logic shutdown_req_unused;
  assign shutdown_req_unused = shutdown_req;
`endif

  dsi_cmd_rom #(
    .MADCTL_VAL (MADCTL_VAL),
    .COLMOD_VAL (COLMOD_VAL)
  ) u_rom (
    .idx   (idx_reg),
    .entry (rom_q)
  );

  always_comb begin
    wait_val = '0;
    case (wait_sel_reg)
      WAIT_SLPOUT: wait_val = SLPOUT_WAIT;
      WAIT_DISPON: wait_val = DISPON_WAIT;
      default:     wait_val = '0;
    endcase
  end

  // Saturating increment: the shared counter never wraps.
  assign cnt_inc = (cnt_reg == '1) ? cnt_reg : cnt_reg + ONE;
  // A wait of W occupies max(W,1) DELAY cycles.
  assign delay_done = (wait_val == '0) || (cnt_reg == wait_val - ONE);

  // State register plus all registered outputs.
  always_ff @(posedge byte_clk) begin
    if (reset) begin
      state_reg    <= S_PWRUP_WAIT;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      wait_sel_reg <= WAIT_NONE;
      req_reg      <= 1'b0;
      dt_reg       <= '0;
      wc_reg       <= '0;
      video_reg    <= 1'b0;
      ini_reg      <= 1'b0;
      err_reg      <= 1'b0;
      dbg_reg      <= dbg_code(S_PWRUP_WAIT);
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      idx_reg      <= idx_next;
      wait_sel_reg <= wait_sel_next;
      req_reg      <= req_next;
      dt_reg       <= dt_next;
      wc_reg       <= wc_next;
      video_reg    <= video_next;
      ini_reg      <= ini_next;
      err_reg      <= err_next;
      dbg_reg      <= dbg_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    timeout    = 1'b0;
    case (state_reg)
      S_PWRUP_WAIT: begin
        if (cnt_reg == POWERUP_WAIT) begin
          state_next = S_LOAD;
          cnt_next   = '0;
          idx_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      S_LOAD:  state_next = S_ISSUE;
      S_ISSUE: begin
        state_next = S_WAIT_BUSY;
        cnt_next   = '0;
      end
      S_WAIT_BUSY: begin
        if (pkt_busy) begin
          state_next = S_WAIT_DONE;
          cnt_next   = '0;
        end else if (cnt_reg == BUSY_LAST) begin
          // Packetizer never answered: flag it and carry on as if sent.
          timeout    = 1'b1;
          state_next = S_DELAY;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      S_WAIT_DONE: begin
        if (!pkt_busy) begin
          state_next = S_DELAY;
          cnt_next   = '0;
        end
      end
      S_DELAY: begin
        if (delay_done) begin
          cnt_next = '0;
          if (idx_reg == IDX_INIT_LAST) begin
            state_next = S_RUN;
`ifdef DSI_SHUTDOWN_EN
          end else if (idx_reg == IDX_SHDN_LAST) begin
            state_next = S_OFF;
`endif
          end else begin
            state_next = S_LOAD;
            idx_next   = idx_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_inc;
        end
      end
      S_RUN: begin
`ifdef DSI_SHUTDOWN_EN
        if (shutdown_req) begin
          state_next = S_DRAIN;
          cnt_next   = '0;
          idx_next   = IDX_SHDN_FIRST;
        end
`endif
      end
`ifdef DSI_SHUTDOWN_EN
      S_DRAIN: begin
        // Wait for two consecutive idle cycles so no video packet is cut.
        if (pkt_busy) begin
          cnt_next = '0;
        end else if (cnt_reg == ONE) begin
          state_next = S_LOAD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      S_OFF: begin
        if (!shutdown_req) begin
          state_next = S_PWRUP_WAIT;
          cnt_next   = '0;
          idx_next   = '0;
        end
      end
`endif
      default: begin
        state_next = S_PWRUP_WAIT;
        cnt_next   = '0;
        idx_next   = '0;
      end
    endcase
  end

  // Output logic: values computed from the upcoming state so every output is
  // a plain flop aligned with state_reg.
  always_comb begin
    req_next      = (state_next == S_ISSUE);
    video_next    = (state_next == S_RUN);
    dt_next       = dt_reg;
    wc_next       = wc_reg;
    wait_sel_next = wait_sel_reg;
    if (state_reg == S_LOAD) begin
      dt_next       = rom_q.dt;
      wc_next       = {rom_q.param, rom_q.opcode};
      wait_sel_next = rom_q.wait_sel;
    end
    // ini_done stays up through the shutdown commands and clears in OFF.
    ini_next = ini_reg;
    if (state_next == S_RUN) begin
      ini_next = 1'b1;
    end else if (state_next == S_OFF) begin
      ini_next = 1'b0;
    end
    err_next = err_reg | timeout;
    dbg_next = dbg_code(state_next);
  end

  assign pkt_req   = req_reg;
  assign pkt_dt    = dt_reg;
  assign pkt_vc    = VC_ID;
  assign pkt_wc    = wc_reg;
  assign video_en  = video_reg;
  assign ini_done  = ini_reg;
  assign err       = err_reg;
  assign state_dbg = dbg_reg;

endmodule

// File: tb/tb_dsi_init_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dsi_init_sequencer
// Directed bench for dsi_init_sequencer. Expected packets go into a scoreboard
// queue when a sequence is started and are popped as pkt_req strobes appear.
// A small packetizer model raises pkt_busy 2 cycles after each request for 8
// cycles. The shutdown scenario is built only with DSI_SHUTDOWN_EN.
// -----------------------------------------------------------------------------
module tb_dsi_init_sequencer;

  localparam int         PW   = 10;
  localparam int         SLP  = 50;
  localparam int         DISP = 20;
  localparam int         BTO  = 16;
  localparam logic [7:0] MAD  = 8'h48;
  localparam logic [7:0] COL  = 8'h66;
  localparam logic [1:0] VC   = 2'd2;

  logic        byte_clk = 1'b0;
  logic        reset = 1'b1;
  logic        pkt_busy = 1'b0;
  logic        shutdown_req = 1'b0;
  logic        pkt_req;
  logic [5:0]  pkt_dt;
  logic [1:0]  pkt_vc;
  logic [15:0] pkt_wc;
  logic        video_en;
  logic        ini_done;
  logic        err;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_count = 0;
  int last_req_cyc = 0;
  int fall_cyc = -100;
  int ini_rise_cyc = -1;
  int err_rise_cyc = -1;
  int pend_cyc = 0;
  bit pend_valid = 1'b0;
  bit pk_en = 1'b1;
  logic prev_ini = 1'b0;
  logic prev_err = 1'b0;
  logic [21:0] exp_q[$];  // {dt, wc}

  dsi_init_sequencer #(
    .DELAY_W      (24),
    .POWERUP_WAIT (24'(PW)),
    .SLPOUT_WAIT  (24'(SLP)),
    .DISPON_WAIT  (24'(DISP)),
    .MADCTL_VAL   (MAD),
    .COLMOD_VAL   (COL),
    .VC_ID        (VC),
    .BUSY_TO      (BTO)
  ) dut (
    .byte_clk     (byte_clk),
    .reset        (reset),
    .pkt_busy     (pkt_busy),
    .shutdown_req (shutdown_req),
    .pkt_req      (pkt_req),
    .pkt_dt       (pkt_dt),
    .pkt_vc       (pkt_vc),
    .pkt_wc       (pkt_wc),
    .video_en     (video_en),
    .ini_done     (ini_done),
    .err          (err),
    .state_dbg    (state_dbg)
  );

  always #5 byte_clk = ~byte_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Monitor: cycle count (1 at the first edge with reset low) and scoreboard.
  initial forever begin
    logic [21:0] e;
    @(posedge byte_clk);
    cyc = reset ? 0 : cyc + 1;
    #1;
    if (pkt_req) begin
      $display("txn %0d cyc=%0d dt=%02h wc=%04h vc=%0d", req_count, cyc, pkt_dt, pkt_wc, pkt_vc);
      req_count++;
      last_req_cyc = cyc;
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("req_dt", 32'(pkt_dt), 32'(e[21:16]));
        chk("req_wc", 32'(pkt_wc), 32'(e[15:0]));
        chk("req_vc", 32'(pkt_vc), 32'(VC));
      end
      if (pk_en) begin
        pend_valid = 1'b1;
        pend_cyc   = cyc;
      end
    end
    if (ini_done && !prev_ini) ini_rise_cyc = cyc;
    prev_ini = ini_done;
    if (err && !prev_err) err_rise_cyc = cyc;
    prev_err = err;
  end

  // Packetizer model: busy sampled high from req+2 to req+9.
  initial forever begin
    @(negedge byte_clk);
    if (pend_valid) begin
      if (cyc == pend_cyc + 1) pkt_busy = 1'b1;
      if (cyc == pend_cyc + 9) begin
        pkt_busy   = 1'b0;
        fall_cyc   = cyc;
        pend_valid = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic push_init();
    exp_q.push_back({6'h05, 16'h0011});
    exp_q.push_back({6'h15, MAD, 8'h36});
    exp_q.push_back({6'h15, COL, 8'h3A});
    exp_q.push_back({6'h05, 16'h0029});
  endtask

  task automatic start_reset();
    @(negedge byte_clk);
    reset = 1'b1;
    pend_valid = 1'b0;
    pkt_busy = 1'b0;
    exp_q.delete();
    req_count = 0;
    fall_cyc = -100;
    ini_rise_cyc = -1;
    err_rise_cyc = -1;
    repeat (3) @(negedge byte_clk);
  endtask

  task automatic wait_req(input int n, input int budget);
    int k = 0;
    while (req_count < n && k < budget) begin
      @(posedge byte_clk); #2; k++;
    end
    chk("req_arrived", 32'(req_count >= n), 32'd1);
  endtask

  task automatic wait_ini(input logic level, input int budget);
    int k = 0;
    while (ini_done !== level && k < budget) begin
      @(posedge byte_clk); #2; k++;
    end
    chk("ini_done_level", 32'(ini_done), 32'(level));
  endtask

  initial begin
    int r0, r1, n;

    // ---- reset state and normal init ----
    start_reset();
    chk("rst_req",   32'(pkt_req),   32'd0);
    chk("rst_dt",    32'(pkt_dt),    32'd0);
    chk("rst_wc",    32'(pkt_wc),    32'd0);
    chk("rst_vc",    32'(pkt_vc),    32'(VC));
    chk("rst_video", 32'(video_en),  32'd0);
    chk("rst_ini",   32'(ini_done),  32'd0);
    chk("rst_err",   32'(err),       32'd0);
    chk("rst_dbg",   32'(state_dbg), 32'd0);
    push_init();
    reset = 1'b0;
    wait_req(1, 100);
    r0 = last_req_cyc;
    chk("req0_cyc", 32'(r0), 32'(PW + 2));
    wait_req(2, 300);
    r1 = last_req_cyc;
    chk("req1_after_slpout", 32'(r1 - fall_cyc), 32'(SLP + 2));
    chk("req1_gap_ge_slp", 32'((r1 - r0) >= SLP), 32'd1);
    wait_req(3, 100);
    chk("req2_after_wait0", 32'(last_req_cyc - fall_cyc), 32'd3);
    wait_req(4, 100);
    chk("req3_after_wait0", 32'(last_req_cyc - fall_cyc), 32'd3);
    chk("ini_low_before_run", 32'(ini_done), 32'd0);
    wait_ini(1'b1, 200);
    chk("ini_rise_delay", 32'(ini_rise_cyc - fall_cyc), 32'(DISP + 1));
    chk("video_with_ini", 32'(video_en), 32'd1);
    chk("run_dbg", 32'(state_dbg), 32'd6);
    chk("no_err", 32'(err), 32'd0);
    repeat (60) @(posedge byte_clk);
    #2;
    chk("no_more_reqs", 32'(req_count), 32'd4);
    chk("sb_drained_1", 32'(exp_q.size()), 32'd0);

    // ---- busy timeout ----
    start_reset();
    pk_en = 1'b0;
    push_init();
    reset = 1'b0;
    wait_req(1, 100);
    r0 = last_req_cyc;
    n = 0;
    while (!err && n < 100) begin
      @(posedge byte_clk); #2; n++;
    end
    chk("err_set", 32'(err), 32'd1);
    chk("err_rise_cyc", 32'(err_rise_cyc - r0), 32'(BTO + 1));
    wait_ini(1'b1, 1000);
    chk("sb_drained_2", 32'(exp_q.size()), 32'd0);
    repeat (30) @(posedge byte_clk);
    #2;
    chk("err_sticky", 32'(err), 32'd1);
    pk_en = 1'b1;

    // ---- reset during sleep-out delay ----
    start_reset();
    chk("err_cleared", 32'(err), 32'd0);
    push_init();
    reset = 1'b0;
    wait_req(1, 100);
    n = 0;
    while (!(fall_cyc > 0 && cyc >= fall_cyc + 10) && n < 100) begin
      @(posedge byte_clk); #2; n++;
    end
    chk("in_slpout_delay", 32'(state_dbg), 32'd5);
    @(negedge byte_clk);
    reset = 1'b1;
    @(posedge byte_clk); #2;
    chk("mid_rst_dbg", 32'(state_dbg), 32'd0);
    chk("mid_rst_dt",  32'(pkt_dt),    32'd0);
    chk("mid_rst_wc",  32'(pkt_wc),    32'd0);
    chk("mid_rst_req", 32'(pkt_req),   32'd0);
    chk("mid_rst_ini", 32'(ini_done),  32'd0);
    start_reset();
    push_init();
    reset = 1'b0;
    wait_req(1, 100);
    chk("restart_req0_cyc", 32'(last_req_cyc), 32'(PW + 2));
    wait_ini(1'b1, 600);
    chk("sb_drained_3", 32'(exp_q.size()), 32'd0);

`ifdef DSI_SHUTDOWN_EN
    // ---- shutdown while video busy ----
    @(negedge byte_clk);
    pk_en = 1'b0;
    pkt_busy = 1'b1;
    shutdown_req = 1'b1;
    @(posedge byte_clk); #2;
    chk("shdn_video_drop", 32'(video_en), 32'd0);
    chk("shdn_ini_held", 32'(ini_done), 32'd1);
    repeat (5) @(negedge byte_clk);
    n = req_count;
    chk("shdn_no_req_while_busy", 32'(req_count), 32'(n));
    exp_q.push_back({6'h05, 16'h0028});
    exp_q.push_back({6'h05, 16'h0010});
    pkt_busy = 1'b0;
    pk_en = 1'b1;
    wait_req(n + 2, 300);
    wait_ini(1'b0, 300);
    chk("off_dbg", 32'(state_dbg), 32'd7);
    chk("off_video", 32'(video_en), 32'd0);
    repeat (20) @(posedge byte_clk);
    #2;
    chk("off_quiet", 32'(req_count), 32'(n + 2));
    @(negedge byte_clk);
    push_init();
    shutdown_req = 1'b0;
    wait_ini(1'b1, 800);
    chk("sb_drained_4", 32'(exp_q.size()), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
